// File: rtl/rr_arb_4_1_if.sv
// Handshake bundle between four valid/ready sources, the round-robin arbiter
// and its downstream consumer. The arbiter uses the slave side.
interface rr_arb_4_1_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic             out_ready;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, sel
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/rr_arb_4_1.sv
// Four-source round-robin arbiter feeding a one-entry output register.
// The most recently granted source gets lowest priority next time.
module rr_arb_4_1 #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  rr_arb_4_1_if.slave  bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       sel_q;
  logic [1:0]       last_q;

  logic             load;
  logic             grant_any;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] win_data;

  assign load = !out_valid_q || bus.out_ready;

  // Scan last+1 .. last+4 (the fourth step wraps back to last itself).
  always_comb begin
    grant_any = 1'b0;
    win       = 2'd0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!grant_any && bus.in_valid[idx]) begin
        grant_any = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    win_data = bus.in_data0;
    case (win)
      2'd0: win_data = bus.in_data0;
      2'd1: win_data = bus.in_data1;
      2'd2: win_data = bus.in_data2;
      2'd3: win_data = bus.in_data3;
      default: win_data = bus.in_data0;
    endcase
  end

  assign bus.in_ready = (load && grant_any) ? (4'b0001 << win) : 4'b0000;

  // last resets to 3 so that source 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
    end else if (load) begin
      if (grant_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        sel_q       <= win;
        last_q      <= win;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed bench for rr_arb_4_1: inputs change just after the falling edge,
// registered outputs are checked at the following falling edge.
module tb_rr_arb_4_1;

  logic clk;
  logic rst_n;
  int   pass_count;
  int   check_count;

  rr_arb_4_1_if #(.WIDTH(4)) bus ();

  rr_arb_4_1 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    bus.in_valid  = 4'b0000;
    bus.in_data0  = 4'h0;
    bus.in_data1  = 4'h0;
    bus.in_data2  = 4'h0;
    bus.in_data3  = 4'h0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_abcd();
    bus.in_data0 = 4'hA;
    bus.in_data1 = 4'hB;
    bus.in_data2 = 4'hC;
    bus.in_data3 = 4'hD;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_count++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid);
    else pass_count++;
    check_count++;
    if (bus.out_data !== 4'h0) $display("[TB] FAIL reset_out_data got %h want 0", bus.out_data);
    else pass_count++;
    check_count++;
    if (bus.sel !== 2'd0) $display("[TB] FAIL reset_sel got %0d want 0", bus.sel);
    else pass_count++;
    check_count++;
    if (bus.in_ready !== 4'b0000) $display("[TB] FAIL reset_in_ready got %b want 0000", bus.in_ready);
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    do_reset();
    bus.in_valid  = 4'b0100;
    bus.in_data2  = 4'hC;
    bus.out_ready = 1'b1;
    #1;
    check_count++;
    if (bus.in_ready !== 4'b0100) $display("[TB] FAIL single_in_ready got %b want 0100", bus.in_ready);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (bus.out_valid !== 1'b1) $display("[TB] FAIL single_out_valid got %0b want 1", bus.out_valid);
    else pass_count++;
    check_count++;
    if (bus.out_data !== 4'hC) $display("[TB] FAIL single_out_data got %h want c", bus.out_data);
    else pass_count++;
    check_count++;
    if (bus.sel !== 2'd2) $display("[TB] FAIL single_sel got %0d want 2", bus.sel);
    else pass_count++;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_data [5];
    logic [1:0] exp_sel  [5];
    logic [3:0] exp_rdy  [5];
    exp_data = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_rdy  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    set_abcd();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check_count++;
    if (bus.in_ready !== 4'b0001) $display("[TB] FAIL rot_first_ready got %b want 0001", bus.in_ready);
    else pass_count++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_count++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data[i] || bus.sel !== exp_sel[i])
        $display("[TB] FAIL rot_word%0d got v=%0b d=%h s=%0d want v=1 d=%h s=%0d",
                 i, bus.out_valid, bus.out_data, bus.sel, exp_data[i], exp_sel[i]);
      else pass_count++;
      check_count++;
      if (bus.in_ready !== exp_rdy[i])
        $display("[TB] FAIL rot_ready%0d got %b want %b", i, bus.in_ready, exp_rdy[i]);
      else pass_count++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_abcd();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_count++;
      if (bus.in_ready !== 4'b0000 || bus.out_data !== 4'hA || bus.sel !== 2'd0 || bus.out_valid !== 1'b1)
        $display("[TB] FAIL bp_hold%0d got r=%b d=%h s=%0d v=%0b want r=0000 d=a s=0 v=1",
                 i, bus.in_ready, bus.out_data, bus.sel, bus.out_valid);
      else pass_count++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check_count++;
    if (bus.in_ready !== 4'b0010) $display("[TB] FAIL bp_release_ready got %b want 0010", bus.in_ready);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (bus.out_data !== 4'hB || bus.sel !== 2'd1)
      $display("[TB] FAIL bp_next_word got d=%h s=%0d want d=b s=1", bus.out_data, bus.sel);
    else pass_count++;
  endtask

  task automatic test_fairness_skip();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'd0, 2'd3, 2'd0, 2'd3};
    do_reset();
    bus.in_data0  = 4'h5;
    bus.in_data3  = 4'h9;
    bus.in_valid  = 4'b1001;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_count++;
      if (bus.sel !== exp_sel[i] || bus.out_data !== ((exp_sel[i] == 2'd0) ? 4'h5 : 4'h9))
        $display("[TB] FAIL skip_grant%0d got s=%0d d=%h want s=%0d d=%h", i, bus.sel, bus.out_data,
                 exp_sel[i], (exp_sel[i] == 2'd0) ? 4'h5 : 4'h9);
      else pass_count++;
    end
  endtask

  task automatic test_drain_no_request();
    do_reset();
    bus.in_valid  = 4'b0100;
    bus.in_data2  = 4'hC;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    check_count++;
    if (bus.in_ready !== 4'b0000) $display("[TB] FAIL drain_in_ready got %b want 0000", bus.in_ready);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hC || bus.sel !== 2'd2)
      $display("[TB] FAIL drain_state got v=%0b d=%h s=%0d want v=0 d=c s=2",
               bus.out_valid, bus.out_data, bus.sel);
    else pass_count++;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_abcd();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_count++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.sel !== 2'd0)
      $display("[TB] FAIL async_reset got v=%0b d=%h s=%0d want v=0 d=0 s=0",
               bus.out_valid, bus.out_data, bus.sel);
    else pass_count++;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_count++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.sel !== 2'd0)
      $display("[TB] FAIL async_first_grant got v=%0b d=%h s=%0d want v=1 d=a s=0",
               bus.out_valid, bus.out_data, bus.sel);
    else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    rst_n       = 1'b1;
    clear_inputs();
    test_reset();
    test_single_source();
    test_rotation();
    test_backpressure();
    test_fairness_skip();
    test_drain_no_request();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/rr_arb_4_1.md
# rr_arb_4_1

Four-requestor round-robin arbiter with a one-entry registered output stage. It sits directly upstream of the 4-to-1 data mux. Each cycle it picks one of four valid/ready sources and latches that source's data. It also presents the winning index on `sel`, so the downstream 4:1 mux or a debug tap can steer on it. Fairness is strict rotation: the most recently granted source has the lowest priority in the next arbitration.

## Interface
- `WIDTH`, default 4: data width of every source and of the output.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in_valid`  input  4  bit i set means source i offers `in_data{i}`.
- `in_data0`..`in_data3`  input  WIDTH each  source data.
- `in_ready`  output  4  one-hot or zero; bit i set means source i is accepted this cycle.
- `out_valid`  output  1  output register holds an unconsumed word.
- `out_data`  output  WIDTH  held word.
- `sel`  output  2  index of the source whose word is in `out_data`.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.

## Operation
- State:
  - `out_valid` and `out_data`.
  - `sel`.
  - `last` (2-bit index of the most recent grant).
- `load` = `!out_valid | out_ready`. The register is either empty or being drained this cycle.
- Arbitration is combinational and evaluated only when `load` is 1.
  - Search order is `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - The first index with `in_valid` set wins.
  - `in_ready[win]` = 1 and every other `in_ready` bit is 0.
- If `load` is 0, or no `in_valid` bit is set, `in_ready` = 0.
- On a grant at the clock edge:
  - `out_data` ← `in_data{win}`
  - `sel` ← `win`
  - `last` ← `win`
  - `out_valid` ← 1
- On `load` with no request: `out_valid` ← 0. `out_data` and `sel` hold their old values. `last` is unchanged.
- When `out_valid` is 1 and `out_ready` is 0, all state holds and `in_ready` = 0.
- Simultaneous drain and grant: the new word replaces the consumed one in the same edge. `out_valid` stays 1, so one word per cycle is sustained.
- Index arithmetic is 2-bit unsigned and wraps 3 → 0.
- A source that deasserts `in_valid` before being granted loses nothing. A source must not change `in_data` while its `in_valid` is high and it has not yet been granted.

## Timing
- Reset (`rst_n` = 0, asynchronous) forces:
  - `out_valid` = 0
  - `out_data` = 0
  - `sel` = 0
  - `last` = 3, so source 0 has first priority after reset.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `last`. It is valid in the same cycle as those inputs.
- Latency is 1 cycle: a word granted at edge N appears on `out_data`/`sel` with `out_valid` = 1 after edge N.
- Throughput is 1 word/cycle while `out_ready` stays high and a request is present.
- Reset mid-transfer discards the held word immediately, without waiting for the clock. The first grant after `rst_n` rises goes to the lowest-index valid source.
- No combinational path from `in_data*` to any output.

## Test plan
- **Reset, then single source:** `in_valid` = 4'b0100, `in_data2` = 'hC, `out_ready` = 1.
  - Same cycle: `in_ready` = 4'b0100.
  - Next cycle: `out_valid` = 1, `out_data` = 'hC, `sel` = 2.
- **Rotation:**
  - Setup: `in_valid` = 4'b1111 held, data 'hA/'hB/'hC/'hD, `out_ready` = 1.
  - Required: grants in order 0,1,2,3,0. `out_data` is 'hA,'hB,'hC,'hD,'hA on consecutive cycles, and `sel` is 0,1,2,3,0.
- **Backpressure:**
  - Setup: as rotation, but `out_ready` = 0 after the first word.
  - Required: `out_data` holds 'hA, `in_ready` = 0, `sel` = 0 for 5 cycles.
  - On release: the next word is 'hB.
- **Fairness skip:** `in_valid` = 4'b1001 held with `out_ready` = 1.
  - Required: grants alternate 0,3,0,3.
  - Required: `last` = 3 after reset, so source 0 is granted first.
- **Drain with no request:** word held, `in_valid` = 0, `out_ready` = 1.
  - Next cycle: `out_valid` = 0, and `out_data`/`sel` are unchanged.
- **Asynchronous reset mid-stream:** pulse `rst_n` low between edges during rotation.
  - Immediately: `out_valid` = 0, `out_data` = 0, `sel` = 0.
  - After release with `in_valid` = 4'b1111: the first grant is source 0.
